ftdi_fifo_bridge: RTL and testbench
===================================

# ftdi_fifo_bridge

Byte-level bridge between the FT245-style asynchronous USB FIFO pins (RXF#/TXE#/RD#/WR#/D[7:0]) and the register command engine. Synchronises the FTDI status flags, generates RD#/WR# strobes with programmable pulse and recovery widths, and exposes the pins as valid/ready byte streams (RX toward the command engine, TX from it). The top level drives the pad tri-state from `data_oe`.

## Interface
- `RD_CYCLES`, default 3: clocks RD# is held low; must be ≥2.
- `WR_CYCLES`, default 3: clocks WR# is held low; must be ≥2.
- `RECOVER_CYCLES`, default 4: idle clocks after each strobe before the flags are trusted again; must be ≥ `SYNC_STAGES`+1.
- `SYNC_STAGES`, default 2: flip-flop stages in each flag synchroniser.
- `clk`  in  1: system clock; every flop is on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `rxf_n`  in  1: FTDI "RX data available", active-low, asynchronous.
- `txe_n`  in  1: FTDI "TX space available", active-low, asynchronous.
- `rd_n`  out  1: read strobe to FTDI, registered.
- `wr_n`  out  1: write strobe to FTDI, registered.
- `data_i`  in  8: pad input data.
- `data_o`  out  8: pad output data, registered.
- `data_oe`  out  1: pad output enable; 1 drives `data_o`.
- `rx_data`  out  8: received byte.
- `rx_valid`  out  1: `rx_data` holds an unconsumed byte.
- `rx_ready`  in  1: consumer accepts `rx_data` when `rx_valid` is also high.
- `tx_data`  in  8: byte to send.
- `tx_valid`  in  1: `tx_data` is valid.
- `tx_ready`  out  1: bridge accepts `tx_data` this cycle.

## Operation
- Reset values: `rd_n`=1, `wr_n`=1, `data_oe`=0, `data_o`=0, `rx_valid`=0, `rx_data`=0, `tx_ready`=0. The FSM resets to IDLE, the synchroniser flops reset to 1 (inactive), and the arbiter resets to favour RX. Reset asserted mid-strobe forces all outputs to these values immediately.
- `rxf_s` and `txe_s` are the synchronised, active-high flags.
- **IDLE**
  - RX request: `rxf_s` & !`rx_valid`.
  - TX request: `txe_s` & `tx_valid`; `tx_ready` is high only in IDLE with TX granted.
  - If both are requested, grant the side that did not win the previous contested grant (round-robin). A single requester always wins.
  - RX grant goes to RD. TX grant latches `tx_data` into `data_o`, sets `data_oe`=1, and goes to WR_SETUP.
- **RD**: `rd_n`=0 for `RD_CYCLES` clocks. On the final edge, `data_i` is captured into `rx_data`, `rx_valid` is set, `rd_n` returns to 1, and the FSM goes to RECOVER.
- **WR_SETUP**: 1 clock with data driven and `wr_n`=1, then WR.
- **WR**: `wr_n`=0 for `WR_CYCLES` clocks, then WR_HOLD.
- **WR_HOLD**: 1 clock with `wr_n`=1 and `data_oe` still 1. `data_oe` drops on exit, then RECOVER.
- **RECOVER**: `RECOVER_CYCLES` clocks with both strobes high and the flags ignored, then IDLE.
- **RX buffer**: one byte. `rx_valid` clears on the `rx_valid`&`rx_ready` edge. No read starts while `rx_valid`=1, so overflow is impossible and no byte is dropped.
- **Flag deassertion**: a flag deasserting before a grant cancels the request. A flag deasserting during a strobe does not abort it.
- **Bus contention**: `data_oe` is never 1 while `rd_n`=0. This is guaranteed because RD is entered only from IDLE with `data_oe`=0.
- **Strobe counter**: single shared down-counter, width clog2(max(RD_CYCLES, WR_CYCLES, RECOVER_CYCLES)+1). Loaded on state entry; the state exits when the counter reaches 1. It does not wrap.

## Timing
- Flag latency: `SYNC_STAGES` clocks from a pin edge to `rxf_s`/`txe_s`, plus 1 clock for the IDLE decision.
- RX byte time: grant edge → `rx_valid` after `RD_CYCLES` clocks.
- Minimum RX period: 1 + `RD_CYCLES` + `RECOVER_CYCLES` clocks (8 at defaults).
- TX byte time: 1 (IDLE) + 1 + `WR_CYCLES` + 1 + `RECOVER_CYCLES` clocks (10 at defaults).
- Setup/hold: `data_o` is stable ≥1 clock before WR# falls and ≥1 clock after WR# rises.
- Consumer back-to-back: `rx_ready` held at 1 must sustain the minimum RX period with no bubbles other than RECOVER.

## Structure
- Shared package `ftdi_bridge_pkg`:
  - state enum (IDLE, RD, WR_SETUP, WR, WR_HOLD, RECOVER);
  - default cycle constants.
- Sub-module `flag_sync`: `SYNC_STAGES`-deep synchroniser with reset value 1, instantiated for `rxf_n` and `txe_n`.
- All remaining logic (FSM, counter, arbiter, RX holding register) lives in one module.

## Test plan
- **Single RX**: rxf_n=0, data_i=0x5A, rx_ready=1 → rd_n low exactly 3 clocks, rx_data=0x5A, rx_valid high 1 clock, then 4 RECOVER clocks.
- **RX back-pressure**: rxf_n=0 with bytes 0x01,0x02 and rx_ready=0 for 20 clocks → only one RD pulse, rx_data=0x01 held. Release rx_ready → second RD pulse, rx_data=0x02.
- **Single TX**: txe_n=0, tx_data=0xC3, tx_valid=1 → one tx_ready cycle, data_oe=1 for 5 clocks, data_o=0xC3, wr_n low 3 clocks inside that window.
- **Contention**: rxf_n=0 and txe_n=0 with tx_valid=1 continuously → strobes alternate RD, WR, RD, WR. Assert data_oe & !rd_n never occurs.
- **Reset mid-strobe**: reset_n=0 during the 2nd clock of WR → wr_n=1, data_oe=0, rx_valid=0 immediately. After release, the first strobe appears no sooner than SYNC_STAGES+1 clocks.
- **Flag glitch**: rxf_n pulses low for 1 clock → no RD strobe issued.

Source files
------------

// File: rtl/ftdi_bridge_pkg.sv
// Shared types and default timing for the FT245 asynchronous FIFO bridge.
package ftdi_bridge_pkg;

   // Bridge sequencer states.
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD       = 3'd1,
      ST_WR_SETUP = 3'd2,
      ST_WR       = 3'd3,
      ST_WR_HOLD  = 3'd4,
      ST_RECOVER  = 3'd5
   } bridge_state_e;

   // Default strobe / recovery widths, in clk cycles.
   localparam int unsigned DEF_RD_CYCLES      = 32'd3;
   localparam int unsigned DEF_WR_CYCLES      = 32'd3;
   localparam int unsigned DEF_RECOVER_CYCLES = 32'd4;
   localparam int unsigned DEF_SYNC_STAGES    = 32'd2;

   // Largest of three cycle counts; sizes the shared strobe counter.
   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return m;
   endfunction

endpackage

// File: rtl/ftdi_fifo_bridge_if.sv
// Byte-stream side of the FTDI bridge: RX toward the command engine,
// TX from it. The bridge is the master, the command engine the slave.
interface ftdi_fifo_bridge_if;

   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (
      output rx_data,
      output rx_valid,
      input  rx_ready,
      input  tx_data,
      input  tx_valid,
      output tx_ready
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      output rx_ready,
      output tx_data,
      output tx_valid,
      input  tx_ready
   );

endinterface

// File: rtl/flag_sync.sv
// Multi-stage synchroniser for an active-low FTDI status pin. Flops reset
// to 1 (flag inactive). The active-high flag is asserted only when the last
// two stages both hold 0, so a pin pulse caught by a single clock edge never
// reaches the sequencer, while assertion latency stays at STAGES clocks.
module flag_sync #(
   parameter int unsigned STAGES = 32'd2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic pin_n,
   output logic flag_s
);

   logic [STAGES-1:0] sync_r;

   // Shift the raw pin level through the synchroniser chain.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_r <= {STAGES{1'b1}};
      end else begin
         sync_r <= {sync_r[STAGES-2:0], pin_n};
      end
   end

   assign flag_s = ~(sync_r[STAGES-1] | sync_r[STAGES-2]);

endmodule

// File: rtl/ftdi_fifo_bridge.sv
// FT245-style FIFO pin bridge: synchronises RXF#/TXE#, sequences RD#/WR#
// strobes with programmable widths, arbitrates RX/TX round-robin and holds
// one received byte for the command engine.
module ftdi_fifo_bridge
   import ftdi_bridge_pkg::*;
#(
   parameter int unsigned RD_CYCLES      = DEF_RD_CYCLES,
   parameter int unsigned WR_CYCLES      = DEF_WR_CYCLES,
   parameter int unsigned RECOVER_CYCLES = DEF_RECOVER_CYCLES,
   parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               rxf_n,
   input  logic               txe_n,
   output logic               rd_n,
   output logic               wr_n,
   input  logic [7:0]         data_i,
   output logic [7:0]         data_o,
   output logic               data_oe,
   ftdi_fifo_bridge_if.master strm
);

   localparam int unsigned CNT_MAX = max3(RD_CYCLES, WR_CYCLES, RECOVER_CYCLES);
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 32'd1);

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
   localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(RD_CYCLES);
   localparam logic [CNT_W-1:0] WR_LOAD  = CNT_W'(WR_CYCLES);
   localparam logic [CNT_W-1:0] REC_LOAD = CNT_W'(RECOVER_CYCLES);

   logic             rxf_s;
   logic             txe_s;
   bridge_state_e    state_r;
   logic [CNT_W-1:0] cnt_r;
   logic             prefer_rx_r;
   logic             rd_n_r;
   logic             wr_n_r;
   logic             data_oe_r;
   logic [7:0]       data_o_r;
   logic [7:0]       rx_data_r;
   logic             rx_valid_r;
   logic             rx_req_s;
   logic             tx_req_s;
   logic             grant_rx_s;
   logic             grant_tx_s;
   logic             contested_s;

   flag_sync #(.STAGES(SYNC_STAGES)) u_rxf_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .pin_n   (rxf_n),
      .flag_s  (rxf_s)
   );

   flag_sync #(.STAGES(SYNC_STAGES)) u_txe_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .pin_n   (txe_n),
      .flag_s  (txe_s)
   );

   // Request and round-robin grant; requests only exist while idle.
   always_comb begin
      rx_req_s   = 1'b0;
      tx_req_s   = 1'b0;
      grant_rx_s = 1'b0;
      grant_tx_s = 1'b0;
      if (state_r == ST_IDLE) begin
         rx_req_s = rxf_s & ~rx_valid_r;
         tx_req_s = txe_s & strm.tx_valid;
         if (rx_req_s && tx_req_s) begin
            grant_rx_s = prefer_rx_r;
            grant_tx_s = ~prefer_rx_r;
         end else begin
            grant_rx_s = rx_req_s;
            grant_tx_s = tx_req_s;
         end
      end else begin
         rx_req_s   = 1'b0;
         tx_req_s   = 1'b0;
         grant_rx_s = 1'b0;
         grant_tx_s = 1'b0;
      end
   end

   assign contested_s = rx_req_s & tx_req_s;

   // Sequencer: strobes, shared down-counter, arbiter memory, RX holding byte.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= ST_IDLE;
         cnt_r       <= {CNT_W{1'b0}};
         prefer_rx_r <= 1'b1;
         rd_n_r      <= 1'b1;
         wr_n_r      <= 1'b1;
         data_oe_r   <= 1'b0;
         data_o_r    <= 8'h00;
         rx_data_r   <= 8'h00;
         rx_valid_r  <= 1'b0;
      end else begin
         if (rx_valid_r && strm.rx_ready) begin
            rx_valid_r <= 1'b0;
         end
         case (state_r)
            ST_IDLE: begin
               if (contested_s) begin
                  prefer_rx_r <= grant_tx_s;
               end
               if (grant_rx_s) begin
                  state_r <= ST_RD;
                  rd_n_r  <= 1'b0;
                  cnt_r   <= RD_LOAD;
               end else if (grant_tx_s) begin
                  state_r   <= ST_WR_SETUP;
                  data_o_r  <= strm.tx_data;
                  data_oe_r <= 1'b1;
               end
            end
            ST_RD: begin
               if (cnt_r == CNT_ONE) begin
                  rx_data_r  <= data_i;
                  rx_valid_r <= 1'b1;
                  rd_n_r     <= 1'b1;
                  state_r    <= ST_RECOVER;
                  cnt_r      <= REC_LOAD;
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end
            ST_WR_SETUP: begin
               wr_n_r  <= 1'b0;
               state_r <= ST_WR;
               cnt_r   <= WR_LOAD;
            end
            ST_WR: begin
               if (cnt_r == CNT_ONE) begin
                  wr_n_r  <= 1'b1;
                  state_r <= ST_WR_HOLD;
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end
            ST_WR_HOLD: begin
               data_oe_r <= 1'b0;
               state_r   <= ST_RECOVER;
               cnt_r     <= REC_LOAD;
            end
            ST_RECOVER: begin
               if (cnt_r == CNT_ONE) begin
                  state_r <= ST_IDLE;
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               rd_n_r    <= 1'b1;
               wr_n_r    <= 1'b1;
               data_oe_r <= 1'b0;
            end
         endcase
      end
   end

   assign rd_n          = rd_n_r;
   assign wr_n          = wr_n_r;
   assign data_o        = data_o_r;
   assign data_oe       = data_oe_r;
   assign strm.rx_data  = rx_data_r;
   assign strm.rx_valid = rx_valid_r;
   // Same-cycle accept: ready is the IDLE TX grant, which itself depends on tx_valid.
   assign strm.tx_ready = grant_tx_s;

endmodule

// File: tb/tb_ftdi_fifo_bridge.sv
// Self-checking bench for ftdi_fifo_bridge: an FTDI chip model feeds RX bytes
// and captures TX bytes, with scoreboard queues on both streams.
module tb_ftdi_fifo_bridge;

   localparam int SYNC = 2;
   localparam int RDC  = 3;
   localparam int WRC  = 3;
   localparam int RECC = 4;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       rxf_n = 1'b1;
   logic       txe_n;
   logic       rd_n;
   logic       wr_n;
   logic [7:0] data_i = 8'h00;
   logic [7:0] data_o;
   logic       data_oe;

   ftdi_fifo_bridge_if strm_if ();

   ftdi_fifo_bridge #(
      .RD_CYCLES(RDC), .WR_CYCLES(WRC), .RECOVER_CYCLES(RECC), .SYNC_STAGES(SYNC)
   ) dut (
      .clk(clk), .reset_n(reset_n), .rxf_n(rxf_n), .txe_n(txe_n),
      .rd_n(rd_n), .wr_n(wr_n), .data_i(data_i), .data_o(data_o),
      .data_oe(data_oe), .strm(strm_if)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   logic [7:0] ftdi_q[$];
   logic [7:0] exp_rx_q[$];
   logic [7:0] tx_src_q[$];
   logic [7:0] exp_tx_q[$];
   bit         strobe_log[$];   // 1 = RD strobe, 0 = WR strobe, in falling-edge order
   int cyc = 0, rd_pulses = 0, wr_pulses = 0, rd_low = 0, wr_low = 0;
   int last_rd_len = 0, last_wr_len = 0, oe_cnt = 0, last_oe_len = 0;
   int rxv_cnt = 0, last_rxv_len = 0, tx_ready_cnt = 0, contention = 0;
   int rd_fall_cyc = 0, rd_period = 0, take_cnt = 0, taken_cnt = 0;
   logic rd_prev = 1'b1, wr_prev = 1'b1, oe_prev = 1'b0, rxv_prev = 1'b0;
   bit glitch_low = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_rx(input logic [7:0] b);
      ftdi_q.push_back(b);
      exp_rx_q.push_back(b);
   endtask

   task automatic send_tx(input logic [7:0] b);
      tx_src_q.push_back(b);
      exp_tx_q.push_back(b);
   endtask

   task automatic wait_pulses(input string tag, input int rd_t, input int wr_t);
      int n;
      n = 0;
      while ((rd_pulses < rd_t || wr_pulses < wr_t) && n < 300) begin
         @(negedge clk);
         #1;
         n++;
      end
      check({tag, "_timeout"}, 32'((rd_pulses >= rd_t) && (wr_pulses >= wr_t)), 32'd1);
      @(posedge clk);
      #1;
   endtask

   // FTDI chip model plus stream monitors, sampled on the falling edge.
   always @(negedge clk) begin
      cyc++;
      if (data_oe && !rd_n) contention++;
      if (!reset_n) begin
         rd_prev = 1'b1; wr_prev = 1'b1; oe_prev = 1'b0; rxv_prev = 1'b0;
         rd_low = 0; wr_low = 0; oe_cnt = 0; rxv_cnt = 0;
      end else begin
         if (!rd_n) begin
            if (rd_prev) begin
               strobe_log.push_back(1'b1);
               rd_period   = cyc - rd_fall_cyc;
               rd_fall_cyc = cyc;
            end
            rd_low++;
         end else if (!rd_prev) begin
            rd_pulses++;
            last_rd_len = rd_low;
            rd_low = 0;
            if (ftdi_q.size() != 0) void'(ftdi_q.pop_front());
         end
         if (!wr_n) begin
            if (wr_prev) strobe_log.push_back(1'b0);
            wr_low++;
         end else if (!wr_prev) begin
            wr_pulses++;
            last_wr_len = wr_low;
            wr_low = 0;
            check("wr_rise_oe_hold", 32'(data_oe), 32'd1);
            check("tx_sb_pending", 32'(exp_tx_q.size() != 0), 32'd1);
            if (exp_tx_q.size() != 0) check("tx_byte", 32'(data_o), 32'(exp_tx_q.pop_front()));
         end
         if (data_oe) oe_cnt++;
         else if (oe_prev) begin last_oe_len = oe_cnt; oe_cnt = 0; end
         if (strm_if.rx_valid) rxv_cnt++;
         else if (rxv_prev) begin last_rxv_len = rxv_cnt; rxv_cnt = 0; end
         if (strm_if.rx_valid && strm_if.rx_ready) begin
            check("rx_sb_pending", 32'(exp_rx_q.size() != 0), 32'd1);
            if (exp_rx_q.size() != 0) check("rx_byte", 32'(strm_if.rx_data), 32'(exp_rx_q.pop_front()));
         end
         if (strm_if.tx_valid && strm_if.tx_ready) take_cnt++;
         if (strm_if.tx_ready) tx_ready_cnt++;
         rd_prev  = rd_n;
         wr_prev  = wr_n;
         oe_prev  = data_oe;
         rxv_prev = strm_if.rx_valid;
      end
      rxf_n  = (glitch_low || ftdi_q.size() != 0) ? 1'b0 : 1'b1;
      data_i = (ftdi_q.size() != 0) ? ftdi_q[0] : 8'h00;
   end

   // Command-engine TX source: present the queue head, advance on acceptance.
   always @(posedge clk) begin
      #2;
      while (taken_cnt < take_cnt) begin
         if (tx_src_q.size() != 0) void'(tx_src_q.pop_front());
         taken_cnt++;
      end
      strm_if.tx_valid = (tx_src_q.size() != 0);
      strm_if.tx_data  = (tx_src_q.size() != 0) ? tx_src_q[0] : 8'h00;
   end

   initial begin
      int n;
      int base;
      reset_n = 1'b1;
      txe_n   = 1'b1;
      strm_if.rx_ready = 1'b0;
      #2 reset_n = 1'b0;
      tick(3);

      // Reset state
      check("rst_rd_n", 32'(rd_n), 32'd1);
      check("rst_wr_n", 32'(wr_n), 32'd1);
      check("rst_data_oe", 32'(data_oe), 32'd0);
      check("rst_data_o", 32'(data_o), 32'h00);
      check("rst_rx_valid", 32'(strm_if.rx_valid), 32'd0);
      check("rst_rx_data", 32'(strm_if.rx_data), 32'h00);
      check("rst_tx_ready", 32'(strm_if.tx_ready), 32'd0);
      reset_n = 1'b1;
      tick(3);

      // Single RX
      strm_if.rx_ready = 1'b1;
      push_rx(8'h5A);
      wait_pulses("rx1", 1, 0);
      tick(3);
      check("rx1_rd_len", 32'(last_rd_len), 32'(RDC));
      check("rx1_data", 32'(strm_if.rx_data), 32'h5A);
      check("rx1_valid_len", 32'(last_rxv_len), 32'd1);

      // Back-to-back RX at the minimum period
      push_rx(8'hA5);
      push_rx(8'h3C);
      wait_pulses("rxbb", 3, 0);
      tick(3);
      check("rx_min_period", 32'(rd_period), 32'(1 + RDC + RECC));

      // RX back-pressure: one byte held, no second read
      strm_if.rx_ready = 1'b0;
      push_rx(8'h01);
      push_rx(8'h02);
      tick(20);
      check("bp_one_pulse", 32'(rd_pulses), 32'd4);
      check("bp_valid_held", 32'(strm_if.rx_valid), 32'd1);
      check("bp_data_held", 32'(strm_if.rx_data), 32'h01);
      strm_if.rx_ready = 1'b1;
      wait_pulses("bp2", 5, 0);
      tick(3);
      check("bp_second", 32'(strm_if.rx_data), 32'h02);
      check("bp_drained", 32'(exp_rx_q.size()), 32'd0);

      // Single TX
      base = tx_ready_cnt;
      txe_n = 1'b0;
      send_tx(8'hC3);
      wait_pulses("tx1", 5, 1);
      tick(3);
      txe_n = 1'b1;
      check("tx1_ready_cycles", 32'(tx_ready_cnt - base), 32'd1);
      check("tx1_oe_len", 32'(last_oe_len), 32'(1 + WRC + 1));
      check("tx1_wr_len", 32'(last_wr_len), 32'(WRC));
      check("tx1_data_o", 32'(data_o), 32'hC3);
      check("tx1_oe_off", 32'(data_oe), 32'd0);

      // Contention: RX and TX requested together must alternate RD, WR, ...
      tick(8);
      strobe_log.delete();
      for (int i = 0; i < 4; i++) begin
         push_rx(8'h10 + 8'(i));
         send_tx(8'h20 + 8'(i));
      end
      txe_n = 1'b0;
      wait_pulses("cont", 9, 5);
      tick(4);
      txe_n = 1'b1;
      check("cont_strobes", 32'(strobe_log.size()), 32'd8);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("cont_order_%0d", i), 32'(strobe_log[i]), 32'((i % 2) == 0));
      end
      check("cont_rx_drained", 32'(exp_rx_q.size()), 32'd0);
      check("cont_tx_drained", 32'(exp_tx_q.size()), 32'd0);

      // Reset during the 2nd clock of WR
      tick(8);
      txe_n = 1'b0;
      send_tx(8'h77);
      n = 0;
      while (wr_n && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("rst_reach_wr", 32'(wr_n), 32'd0);
      @(posedge clk);
      #1 reset_n = 1'b0;
      #1;
      check("mid_rst_wr_n", 32'(wr_n), 32'd1);
      check("mid_rst_data_oe", 32'(data_oe), 32'd0);
      check("mid_rst_rx_valid", 32'(strm_if.rx_valid), 32'd0);
      check("mid_rst_rd_n", 32'(rd_n), 32'd1);
      exp_tx_q.delete();
      base = wr_pulses;
      send_tx(8'h88);
      tick(2);
      reset_n = 1'b1;
      n = 0;
      while (wr_n && rd_n && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      // Flag sync, IDLE decision (data_oe), then WR_SETUP before WR# falls.
      check("rst_first_strobe_clks", 32'(n), 32'(SYNC + 2));
      wait_pulses("rst_tx", 0, base + 1);
      tick(6);
      txe_n = 1'b1;

      // One-clock RXF# glitch must not start a read
      tick(10);
      strobe_log.delete();
      base = rd_pulses;
      glitch_low = 1'b1;
      tick(1);
      glitch_low = 1'b0;
      tick(20);
      check("glitch_no_strobe", 32'(strobe_log.size()), 32'd0);
      check("glitch_no_pulse", 32'(rd_pulses), 32'(base));

      // Final scoreboard and bus-contention state
      check("end_rx_drained", 32'(exp_rx_q.size()), 32'd0);
      check("end_tx_drained", 32'(exp_tx_q.size()), 32'd0);
      check("bus_contention", 32'(contention), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
